// File: rtl/param_issue_queue_pkg.sv
// Shared CPU types for the issue queue: opcode set, decoded task payload,
// reservation-station class and the opcode-to-class mapping.
package param_issue_queue_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned TAG_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_STORE = 3'd0,
        OP_LOAD  = 3'd1,
        OP_NOP   = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_AND   = 3'd5,
        OP_OR    = 3'd6,
        OP_MUL   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t          op;
        logic [RD_W-1:0]  rd;
        logic [TAG_W-1:0] tag;
    } task_t;

    typedef enum logic [1:0] {
        RS_STORE = 2'd0,
        RS_LOAD  = 2'd1,
        RS_ALU   = 2'd2
    } rs_class_t;

    // Every opcode that is neither a store nor a load goes to the ALU stations.
    function automatic rs_class_t opcode_to_class(input opcode_t op);
        case (op)
            OP_STORE: return RS_STORE;
            OP_LOAD:  return RS_LOAD;
            default:  return RS_ALU;
        endcase
    endfunction

endpackage

// File: rtl/param_issue_queue_rs_select.sv
// iq_rs_select: picks the lowest-index reservation station of a class that is
// neither busy nor claimed by last cycle's dispatch.
//   cls     - requested RS class
//   busy    - flat RS busy vector, N_RS stations per class
//   claim   - one-hot mask of the station dispatched last cycle
//   found_c - an eligible station exists (combinational)
//   index_c - flat index of that station (combinational)
module iq_rs_select
    import param_issue_queue_pkg::*;
#(
    parameter  int unsigned N_RS = 2,
    localparam int unsigned RS_N = 3 * N_RS,
    localparam int unsigned RS_W = $clog2(RS_N)
) (
    input  rs_class_t       cls,
    input  logic [RS_N-1:0] busy,
    input  logic [RS_N-1:0] claim,
    output logic            found_c,
    output logic [RS_W-1:0] index_c
);

    logic [RS_N-1:0] avail_c;

    assign avail_c = ~busy & ~claim;

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        found_c = 1'b0;
        index_c = '0;
        for (int j = int'(RS_N) - 1; j >= 0; j--) begin
            if (avail_c[j] && ((j / int'(N_RS)) == int'(cls))) begin
                found_c = 1'b1;
                index_c = RS_W'(j);
            end
        end
    end

endmodule

// File: rtl/param_issue_queue.sv
// param_issue_queue: in-order issue queue between decode and the reservation
// stations. Accepts up to two tasks per cycle, dispatches at most one head
// task per cycle to the lowest free RS of its class; NOPs retire silently.
//   CLK, RST_N       - clock, synchronous active-low reset
//   ENQ_VALID[1:0]   - [0] ENQ_TASK_0 (older) valid, [1] ENQ_TASK_1 valid
//   FULL             - fewer than two free entries; enqueue is dropped
//   COUNT            - occupancy
//   RS_BUSY          - STORE / LOAD / ALU station busy flags, N_RS each
//   DISP_VALID       - one-cycle dispatch pulse, qualifies DISP_TASK/DISP_RS
//   DISP_TASK        - dispatched task
//   DISP_RS          - flat RS index into RS_BUSY
//   FLUSH            - present only when IQ_FLUSH_EN is defined; empties queue
module param_issue_queue
    import param_issue_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned N_RS  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned RS_N  = 3 * N_RS,
    localparam int unsigned RS_W  = $clog2(RS_N)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       ENQ_VALID,
    input  task_t            ENQ_TASK_0,
    input  task_t            ENQ_TASK_1,
    output logic             FULL,
    output logic [CNT_W-1:0] COUNT,
    input  logic [RS_N-1:0]  RS_BUSY,
`ifdef IQ_FLUSH_EN
    input  logic             FLUSH,
`endif
    output logic             DISP_VALID,
    output task_t            DISP_TASK,
    output logic [RS_W-1:0]  DISP_RS
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    task_t            mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q, head_d, tail_d;
    logic [CNT_W-1:0] count_d;
    logic             full_d;
    logic [RS_N-1:0]  claim_q, claim_d;
    logic             disp_valid_d;
    task_t            disp_task_d;
    logic [RS_W-1:0]  disp_rs_d;

    task_t            head_task_c;
    logic             head_nop_c;
    rs_class_t        head_cls_c;
    logic             found_c;
    logic [RS_W-1:0]  sel_idx_c;
    logic             not_empty_c;
    logic             fire_c;
    logic             pop_c;
    logic             flush_c;
    logic             wr_en_c;
    logic [1:0]       n_push_c;
    logic [PTR_W-1:0] wr_addr1_c;

`ifdef IQ_FLUSH_EN
    assign flush_c = FLUSH;
`else
    assign flush_c = 1'b0;
`endif

    assign head_task_c = mem[head_q];
    assign head_nop_c  = (head_task_c.op == OP_NOP);
    assign head_cls_c  = opcode_to_class(head_task_c.op);
    assign not_empty_c = (COUNT != '0);

    iq_rs_select #(.N_RS(N_RS)) u_rs_select (
        .cls     (head_cls_c),
        .busy    (RS_BUSY),
        .claim   (claim_q),
        .found_c (found_c),
        .index_c (sel_idx_c)
    );

    // Enqueue is all-or-nothing on FULL; valid tasks are packed from the tail.
    assign wr_en_c    = !FULL && !flush_c;
    assign n_push_c   = wr_en_c ? (2'(ENQ_VALID[0]) + 2'(ENQ_VALID[1])) : 2'd0;
    assign wr_addr1_c = ENQ_VALID[0] ? (tail_q + PTR_W'(1)) : tail_q;

    assign fire_c = not_empty_c && !head_nop_c && found_c && !flush_c;
    assign pop_c  = not_empty_c && (head_nop_c || found_c) && !flush_c;

    // Next-state for pointers, occupancy, claim mask and dispatch outputs.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = COUNT;
        claim_d      = '0;
        disp_valid_d = 1'b0;
        disp_task_d  = DISP_TASK;
        disp_rs_d    = DISP_RS;
        if (flush_c) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_c) head_d = head_q + PTR_W'(1);
            tail_d  = tail_q + PTR_W'(n_push_c);
            count_d = COUNT + CNT_W'(n_push_c) - CNT_W'(pop_c);
            if (fire_c) begin
                disp_valid_d = 1'b1;
                disp_task_d  = head_task_c;
                disp_rs_d    = sel_idx_c;
                // RS_BUSY lags one cycle, so block the just-used station.
                claim_d      = RS_N'(1) << sel_idx_c;
            end
        end
        full_d = (count_d > CNT_W'(DEPTH - 2));
    end

    // Control and output registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head_q     <= '0;
            tail_q     <= '0;
            COUNT      <= '0;
            FULL       <= 1'b0;
            claim_q    <= '0;
            DISP_VALID <= 1'b0;
            DISP_TASK  <= '0;
            DISP_RS    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            COUNT      <= count_d;
            FULL       <= full_d;
            claim_q    <= claim_d;
            DISP_VALID <= disp_valid_d;
            DISP_TASK  <= disp_task_d;
            DISP_RS    <= disp_rs_d;
        end
    end

    // Task storage; contents need no reset since COUNT gates every read.
    always_ff @(posedge CLK) begin
        if (RST_N && wr_en_c) begin
            if (ENQ_VALID[0]) mem[tail_q]     <= ENQ_TASK_0;
            if (ENQ_VALID[1]) mem[wr_addr1_c] <= ENQ_TASK_1;
        end
    end

endmodule

// File: tb/tb_param_issue_queue.sv
// Self-checking bench for param_issue_queue. A queue-based reference model
// predicts occupancy, FULL and every dispatch from the queue's rules.
module tb_param_issue_queue;
    import param_issue_queue_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned N_RS  = 2;
    localparam int unsigned RS_N  = 3 * N_RS;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RS_W  = $clog2(RS_N);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       enq_valid;
    task_t            enq_task_0, enq_task_1;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [RS_N-1:0]  rs_busy;
    logic             flush = 1'b0;
    logic             disp_valid;
    task_t            disp_task;
    logic [RS_W-1:0]  disp_rs;

    int checks = 0;
    int errors = 0;
    int tag_ctr = 0;

    // Reference model state
    task_t m_q[$];
    int    m_last_rs = -1;
    logic  m_dv = 1'b0;
    task_t m_task = '0;
    int    m_rs = 0;
    logic  m_full = 1'b0;

    always #5 clk = ~clk;

    param_issue_queue #(.DEPTH(DEPTH), .N_RS(N_RS)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .ENQ_VALID  (enq_valid),
        .ENQ_TASK_0 (enq_task_0),
        .ENQ_TASK_1 (enq_task_1),
        .FULL       (full),
        .COUNT      (count),
        .RS_BUSY    (rs_busy),
`ifdef IQ_FLUSH_EN
        .FLUSH      (flush),
`endif
        .DISP_VALID (disp_valid),
        .DISP_TASK  (disp_task),
        .DISP_RS    (disp_rs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic task_t mk(input opcode_t op);
        task_t t;
        t.op  = op;
        t.rd  = RD_W'($urandom);
        t.tag = TAG_W'(tag_ctr);
        tag_ctr++;
        return t;
    endfunction

    // One clock edge of the reference model, using the inputs held at the edge.
    task automatic model_edge();
        int    base;
        int    pick;
        bit    was_full;
        task_t h;
        if (!rst_n || flush) begin
            m_q.delete();
            m_last_rs = -1;
            m_dv      = 1'b0;
            m_full    = 1'b0;
            if (!rst_n) begin
                m_task = '0;
                m_rs   = 0;
            end
            return;
        end
        was_full = (m_q.size() > int'(DEPTH) - 2);
        m_dv     = 1'b0;
        pick     = -1;
        if (m_q.size() > 0) begin
            h = m_q[0];
            if (h.op == OP_NOP) begin
                void'(m_q.pop_front());
            end else begin
                base = (h.op == OP_STORE) ? 0 : (h.op == OP_LOAD) ? int'(N_RS) : 2 * int'(N_RS);
                for (int i = 0; i < int'(N_RS); i++) begin
                    if (pick < 0 && !rs_busy[base + i] && (base + i) != m_last_rs) pick = base + i;
                end
                if (pick >= 0) begin
                    m_dv   = 1'b1;
                    m_task = h;
                    m_rs   = pick;
                    void'(m_q.pop_front());
                end
            end
        end
        m_last_rs = pick;
        if (!was_full) begin
            if (enq_valid[0]) m_q.push_back(enq_task_0);
            if (enq_valid[1]) m_q.push_back(enq_task_1);
        end
        m_full = (m_q.size() > int'(DEPTH) - 2);
    endtask

    task automatic step(input logic r, input logic [1:0] ev, input task_t a, input task_t b,
                        input logic [RS_N-1:0] busy, input logic fl);
        rst_n      = r;
        enq_valid  = ev;
        enq_task_0 = a;
        enq_task_1 = b;
        rs_busy    = busy;
        flush      = fl;
        @(posedge clk);
        model_edge();
        #1;
        check("count", 32'(count), 32'(m_q.size()));
        check("full", 32'(full), 32'(m_full));
        check("disp_valid", 32'(disp_valid), 32'(m_dv));
        if (m_dv) begin
            check("disp_task", 32'(disp_task), 32'(m_task));
            check("disp_rs", 32'(disp_rs), 32'(m_rs));
        end
    endtask

    task automatic idle(input int n, input logic [RS_N-1:0] busy);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, '0, '0, busy, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        enq_valid  = 2'b00;
        enq_task_0 = '0;
        enq_task_1 = '0;
        rs_busy    = '0;

        // Reset while both enqueue inputs are active
        step(1'b0, 2'b11, mk(OP_ADD), mk(OP_LOAD), '0, 1'b0);
        step(1'b0, 2'b11, mk(OP_ADD), mk(OP_LOAD), '0, 1'b0);
        check("rst_disp_task", 32'(disp_task), 32'd0);
        check("rst_disp_rs", 32'(disp_rs), 32'd0);
        idle(1, '0);

        // Fill with all stations busy; later pairs are dropped once FULL
        for (int i = 0; i < 9; i++) step(1'b1, 2'b11, mk(OP_ADD), mk(OP_SUB), '1, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'(DEPTH));
        idle(DEPTH + 4, '0);

        // LOAD then ALU: LOAD_0 then ALU_0 on consecutive cycles
        step(1'b1, 2'b11, mk(OP_LOAD), mk(OP_ADD), '0, 1'b0);
        idle(4, '0);

        // Three stores with stations never reporting busy: claim alternates them
        step(1'b1, 2'b11, mk(OP_STORE), mk(OP_STORE), '0, 1'b0);
        step(1'b1, 2'b01, mk(OP_STORE), '0, '0, 1'b0);
        idle(5, '0);

        // Single younger-slot enqueue is compacted to the tail
        step(1'b1, 2'b10, '0, mk(OP_MUL), '0, 1'b0);
        idle(3, '0);

        // NOP/ALU mix with random busy; many pointer wraps
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 2'($urandom),
                 mk(($urandom_range(0, 1) == 0) ? OP_NOP : OP_ADD),
                 mk(($urandom_range(0, 2) == 0) ? OP_NOP : OP_OR),
                 RS_N'($urandom) & RS_N'($urandom), 1'b0);
        end
        idle(DEPTH * 2, '0);

        // Fully random opcodes and busy pattern
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'($urandom), mk(opcode_t'(OP_W'($urandom))), mk(opcode_t'(OP_W'($urandom))),
                 RS_N'($urandom), 1'b0);
        end

`ifdef IQ_FLUSH_EN
        // Flush with five entries and a concurrent enqueue
        idle(DEPTH * 2, '0);
        step(1'b1, 2'b11, mk(OP_ADD), mk(OP_ADD), '1, 1'b0);
        step(1'b1, 2'b11, mk(OP_ADD), mk(OP_ADD), '1, 1'b0);
        step(1'b1, 2'b01, mk(OP_ADD), '0, '1, 1'b0);
        check("pre_flush_count", 32'(count), 32'd5);
        step(1'b1, 2'b11, mk(OP_ADD), mk(OP_ADD), '0, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_dv", 32'(disp_valid), 32'd0);
        // Reset wins over flush
        step(1'b0, 2'b11, mk(OP_ADD), mk(OP_ADD), '0, 1'b1);
        idle(3, '0);
`endif

        // Mid-run reset with traffic pending
        for (int i = 0; i < 6; i++) step(1'b1, 2'b11, mk(OP_LOAD), mk(OP_STORE), '1, 1'b0);
        step(1'b0, 2'b11, mk(OP_ADD), mk(OP_ADD), '0, 1'b0);
        check("rst2_count", 32'(count), 32'd0);
        idle(3, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
